// File: rtl/soc_pkg.sv
// Shared memory map, region decode and core-side enums/helpers for the RV32I SoC.
package soc_pkg;

  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] LED_ADDR = 32'h2000_0000;

  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM, REG_LED} region_e;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} core_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Regions are 256 MiB windows keyed on addr[31:28]; anything past the
  // populated depth falls back to REG_NONE.
  function automatic region_e decode_region(input logic [31:0] a,
                                            input logic [31:0] rom_words,
                                            input logic [31:0] ram_words);
    region_e r;
    r = REG_NONE;
    if (a[31:28] == ROM_BASE[31:28] && {6'h0, a[27:2]} < rom_words) r = REG_ROM;
    else if (a[31:28] == RAM_BASE[31:28] && {6'h0, a[27:2]} < ram_words) r = REG_RAM;
    else if (a == LED_ADDR) r = REG_LED;
    return r;
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic [31:0] y;
    case (f3)
      3'd0:    y = alt ? a - b : a + b;
      3'd1:    y = a << b[4:0];
      3'd2:    y = {31'h0, $signed(a) < $signed(b)};
      3'd3:    y = {31'h0, a < b};
      3'd4:    y = a ^ b;
      3'd5:    y = alt ? $signed(a) >>> b[4:0] : a >> b[4:0];
      3'd6:    y = a | b;
      default: y = a & b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/open_risc_v.sv
// Compact RV32I core: fetch / execute / load-writeback, 1-cycle synchronous memories.
module open_risc_v
  import soc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ROM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i
);
  core_state_e r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, r_inst, w_inst;
  logic [31:0] r_regs [0:31];
  logic        w_rd_we;
  logic [31:0] w_rd_val;

  // A ROM-sourced load reuses the fetch port, so the instruction is held in r_inst.
  assign w_inst      = (r_state == S_EXEC) ? inst_i : r_inst;
  assign inst_addr_o = r_pc;

  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_sh;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1v, w_rs2v, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_ld_raw;
  logic        w_take;

  assign w_op    = w_inst[6:0];
  assign w_rd    = w_inst[11:7];
  assign w_f3    = w_inst[14:12];
  assign w_rs1   = w_inst[19:15];
  assign w_rs2   = w_inst[24:20];
  assign w_rs1v  = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
  assign w_rs2v  = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];
  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'h0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  assign mem_addr_o = w_rs1v + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_sh       = {mem_addr_o[1:0], 3'b000};
  assign w_ld_raw   = mem_rdata_i >> w_sh;

  always_comb begin
    case (w_f3)
      3'd0:    w_take = (w_rs1v == w_rs2v);
      3'd1:    w_take = (w_rs1v != w_rs2v);
      3'd4:    w_take = ($signed(w_rs1v) <  $signed(w_rs2v));
      3'd5:    w_take = ($signed(w_rs1v) >= $signed(w_rs2v));
      3'd6:    w_take = (w_rs1v <  w_rs2v);
      3'd7:    w_take = (w_rs1v >= w_rs2v);
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0000_0013;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == S_EXEC) r_inst <= inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_val;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rd_we     = 1'b0;
    w_rd_val    = 32'h0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_wstrb_o = 4'h0;
    mem_wdata_o = 32'h0;
    case (r_state)
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc + 32'd4;
        case (w_op)
          OP_LUI:   begin w_rd_we = 1'b1; w_rd_val = w_imm_u; end
          OP_AUIPC: begin w_rd_we = 1'b1; w_rd_val = r_pc + w_imm_u; end
          OP_JAL:   begin w_rd_we = 1'b1; w_rd_val = r_pc + 32'd4; w_pc_nxt = r_pc + w_imm_j; end
          OP_JALR:  begin
            w_rd_we  = 1'b1;
            w_rd_val = r_pc + 32'd4;
            w_pc_nxt = (w_rs1v + w_imm_i) & ~32'h1;
          end
          OP_BRANCH: if (w_take) w_pc_nxt = r_pc + w_imm_b;
          OP_LOAD:  begin mem_re_o = 1'b1; w_state_nxt = S_LOAD; w_pc_nxt = r_pc; end
          OP_STORE: begin
            mem_we_o    = 1'b1;
            mem_wdata_o = w_rs2v << w_sh;
            case (w_f3[1:0])
              2'd0:    mem_wstrb_o = 4'b0001 << mem_addr_o[1:0];
              2'd1:    mem_wstrb_o = 4'b0011 << mem_addr_o[1:0];
              default: mem_wstrb_o = 4'b1111;
            endcase
          end
          OP_IMM: begin
            w_rd_we  = 1'b1;
            w_rd_val = alu(w_rs1v, w_imm_i, w_f3, (w_f3 == 3'd5) && w_inst[30]);
          end
          OP_REG: begin w_rd_we = 1'b1; w_rd_val = alu(w_rs1v, w_rs2v, w_f3, w_inst[30]); end
          default: ;
        endcase
      end
      S_LOAD: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc + 32'd4;
        w_rd_we     = 1'b1;
        case (w_f3)
          3'd0:    w_rd_val = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
          3'd1:    w_rd_val = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
          3'd4:    w_rd_val = {24'h0, w_ld_raw[7:0]};
          3'd5:    w_rd_val = {16'h0, w_ld_raw[15:0]};
          default: w_rd_val = w_ld_raw;
        endcase
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end
endmodule

// File: rtl/open_riscv_soc_mem.sv
// Byte-strobed 1W/1R synchronous RAM template and the ROM/RAM wrappers built on it.
module dual_ram_template #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_wstrb,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  reg [31:0] memory [0:DEPTH-1];

  // Read samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (i_we && i_wstrb[i]) memory[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    o_rdata <= memory[i_raddr];
  end
endmodule

module dual_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_wstrb,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  dual_ram_template #(.DEPTH(DEPTH), .AW(AW)) dual_ram_template_inst (
    .clk(clk), .i_we(i_we), .i_waddr(i_waddr), .i_wstrb(i_wstrb),
    .i_wdata(i_wdata), .i_raddr(i_raddr), .o_rdata(o_rdata)
  );
endmodule

module rom #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  dual_ram #(.DEPTH(DEPTH), .AW(AW)) rom_mem (
    .clk(clk), .i_we(1'b0), .i_waddr('0), .i_wstrb(4'h0),
    .i_wdata(32'h0), .i_raddr(i_raddr), .o_rdata(o_rdata)
  );
endmodule

module ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_wstrb,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  dual_ram #(.DEPTH(DEPTH), .AW(AW)) ram_mem (
    .clk(clk), .i_we(i_we), .i_waddr(i_addr), .i_wstrb(i_wstrb),
    .i_wdata(i_wdata), .i_raddr(i_addr), .o_rdata(o_rdata)
  );
endmodule

// File: rtl/open_riscv_soc.sv
// SoC top: RV32I core, instruction ROM, data RAM and LED register with address decode.
module open_riscv_soc
  import soc_pkg::*;
#(
  parameter int ROM_DEPTH = 1024,
  parameter int RAM_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led
);
  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [31:0] w_inst_addr, w_inst, w_mem_addr, w_mem_wdata, w_mem_rdata;
  logic [31:0] w_rom_rdata, w_ram_rdata;
  logic [3:0]  w_mem_wstrb;
  logic        w_mem_we, w_mem_re, w_rom_data_rd, w_ram_we, w_unused;
  logic [ROM_AW-1:0] w_rom_raddr;
  logic [7:0]  r_led;
  region_e     w_sel, r_rd_sel;

  open_risc_v #(.RESET_PC(ROM_BASE)) u_core (
    .clk(clk), .rst(rst),
    .inst_addr_o(w_inst_addr), .inst_i(w_inst),
    .mem_addr_o(w_mem_addr), .mem_wdata_o(w_mem_wdata), .mem_we_o(w_mem_we),
    .mem_wstrb_o(w_mem_wstrb), .mem_re_o(w_mem_re), .mem_rdata_i(w_mem_rdata)
  );

  assign w_sel         = decode_region(w_mem_addr, 32'(ROM_DEPTH), 32'(RAM_DEPTH));
  // Core never fetches while a load is in flight, so ROM data reads borrow the fetch port.
  assign w_rom_data_rd = w_mem_re && (w_sel == REG_ROM);
  assign w_rom_raddr   = w_rom_data_rd ? w_mem_addr[ROM_AW+1:2] : w_inst_addr[ROM_AW+1:2];
  assign w_ram_we      = w_mem_we && (w_sel == REG_RAM);
  assign w_inst        = w_rom_rdata;
  assign w_unused      = ^{w_inst_addr[31:ROM_AW+2], w_inst_addr[1:0]};

  rom #(.DEPTH(ROM_DEPTH), .AW(ROM_AW)) rom_inst (
    .clk(clk), .i_raddr(w_rom_raddr), .o_rdata(w_rom_rdata)
  );

  ram #(.DEPTH(RAM_DEPTH), .AW(RAM_AW)) ram_inst (
    .clk(clk), .i_we(w_ram_we), .i_addr(w_mem_addr[RAM_AW+1:2]),
    .i_wstrb(w_mem_wstrb), .i_wdata(w_mem_wdata), .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led    <= 8'h00;
      r_rd_sel <= REG_NONE;
    end else begin
      r_rd_sel <= w_mem_re ? w_sel : REG_NONE;
      if (w_mem_we && w_mem_wstrb[0] && w_sel == REG_LED) r_led <= w_mem_wdata[7:0];
    end
  end

  always_comb begin
    w_mem_rdata = 32'h0;
    case (r_rd_sel)
      REG_ROM: w_mem_rdata = w_rom_rdata;
      REG_RAM: w_mem_rdata = w_ram_rdata;
      REG_LED: w_mem_rdata = {24'h0, r_led};
      default: w_mem_rdata = 32'h0;
    endcase
  end

  assign led = r_led;
endmodule

// File: tb/tb_open_riscv_soc.sv
// Directed programs for the SoC; expected LED/memory values are hand-derived.
module tb_open_riscv_soc;
  typedef logic [31:0] word_q [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led;
  int         n_chk = 0;
  int         n_err = 0;

  open_riscv_soc dut (.clk(clk), .rst(rst), .led(led));

  always #5 clk = ~clk;

  localparam logic [31:0] JAL_SELF = 32'h0000_006F;

  function automatic logic [31:0] e_lui(input int rd, input int imm20);
    return {20'(imm20), 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] e_i(input int op, input int f3, input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = 32'(imm);
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] e_s(input int f3, input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = 32'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_add(input int rd, input int rs1, input int rs2);
    return {7'h0, 5'(rs2), 5'(rs1), 3'h0, 5'(rd), 7'h33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic boot(input word_q p);
    rst = 1'b1;
    for (int i = 0; i < p.size(); i++)
      dut.rom_inst.rom_mem.dual_ram_template_inst.memory[i] <= p[i];
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_led(input string tag, input logic [7:0] exp, input int max);
    int n;
    n = 0;
    while (led !== exp && n < max) begin
      tick();
      n++;
    end
    chk(tag, {24'h0, led}, {24'h0, exp});
  endtask

  initial begin
    word_q p;

    // LED store program, also used for the reset checks.
    p = '{e_lui(1, 32'h20000), e_i(7'h13, 0, 2, 0, 32'hA5), e_s(0, 2, 1, 0), JAL_SELF};
    boot(p);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_pc", dut.w_inst_addr, 32'h0000_0000);
    wait_led("led_store", 8'hA5, 20);
    repeat (10) tick();
    chk("led_hold", {24'h0, led}, 32'hA5);

    // Mid-run reset: LED clears on the reset edge, program re-runs.
    rst = 1'b1;
    tick();
    chk("midrst_led", {24'h0, led}, 32'h0);
    chk("midrst_pc", dut.w_inst_addr, 32'h0000_0000);
    rst = 1'b0;
    wait_led("midrst_rerun", 8'hA5, 20);

    // RAM round trip: sw 0x12345678 @0x1000_0010, lb @+1 -> 0x56.
    p = '{e_lui(1, 32'h10000), e_i(7'h13, 0, 1, 1, 32'h10),
          e_lui(2, 32'h12345), e_i(7'h13, 0, 2, 2, 32'h678),
          e_s(2, 2, 1, 0), e_i(7'h03, 0, 3, 1, 1),
          e_lui(4, 32'h20000), e_s(0, 3, 4, 0), JAL_SELF};
    boot(p);
    repeat (60) tick();
    chk("ram_rt_led", {24'h0, led}, 32'h56);
    chk("ram_rt_word", dut.ram_inst.ram_mem.dual_ram_template_inst.memory[4], 32'h1234_5678);

    // Byte strobe: LED first set to FF, then byte +2 of the cleared lane.
    p = '{e_lui(1, 32'h10000), e_i(7'h13, 0, 1, 1, 32'h20), e_i(7'h13, 0, 2, 0, -1),
          e_lui(4, 32'h20000), e_s(0, 2, 4, 0), e_s(2, 2, 1, 0), e_s(0, 0, 1, 2),
          e_i(7'h03, 2, 3, 1, 0), e_i(7'h13, 5, 3, 3, 16), e_s(0, 3, 4, 0), JAL_SELF};
    boot(p);
    repeat (60) tick();
    chk("strb_led", {24'h0, led}, 32'h00);
    chk("strb_word", dut.ram_inst.ram_mem.dual_ram_template_inst.memory[8], 32'hFF00_FFFF);

    // Unmapped read returns zero: LED goes 5A -> 00.
    p = '{e_lui(4, 32'h20000), e_i(7'h13, 0, 2, 0, 32'h5A), e_s(0, 2, 4, 0),
          e_lui(1, 32'h30000), e_i(7'h03, 2, 3, 1, 0), e_s(0, 3, 4, 0), JAL_SELF};
    boot(p);
    repeat (60) tick();
    chk("unmapped_led", {24'h0, led}, 32'h00);

    // ROM write dropped: word 0 stays 0x07F00113, read back low byte 0x13.
    p = '{e_i(7'h13, 0, 2, 0, 32'h7F), e_s(2, 2, 0, 0), e_i(7'h03, 2, 3, 0, 0),
          e_lui(4, 32'h20000), e_s(0, 3, 4, 0), JAL_SELF};
    boot(p);
    repeat (60) tick();
    chk("rom_wr_led", {24'h0, led}, 32'h13);
    chk("rom_wr_word", dut.rom_inst.rom_mem.dual_ram_template_inst.memory[0], 32'h07F0_0113);

    // LED lanes: sw keeps only byte 0, sb to LED+1 ignored, readback upper bits zero.
    p = '{e_lui(4, 32'h20000), e_lui(2, 32'h12345), e_i(7'h13, 0, 2, 2, 32'h6C3),
          e_s(2, 2, 4, 0), e_s(0, 0, 4, 1), e_i(7'h03, 2, 3, 4, 0),
          e_i(7'h13, 5, 5, 3, 8), e_add(6, 3, 5), e_i(7'h13, 0, 6, 6, 1),
          e_s(0, 6, 4, 0), JAL_SELF};
    boot(p);
    repeat (60) tick();
    chk("led_lanes", {24'h0, led}, 32'hC4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
